// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Round-robin scheduler sharing one UART transmitter host port between
//   NUM_REQ byte requesters, and owner of the UART configuration registers.
//   New configuration is staged in shadow registers and applied only while
//   idle, so a frame is never sent with mixed settings.
//
// Ports
//   clk, rst_n         system clock (rising edge), async active-low reset
//   req_valid/req_data per-requester byte handshake (byte i at [8i+7:8i])
//   req_ready          one-hot acceptance pulse (combinational)
//   grant_id           index of the last accepted requester
//   host_tx_data/en    byte and one-cycle start pulse to the UART core
//   host_tx_busy       UART core busy indication
//   cfg_wr, cfg_*      configuration write strobe and new values
//   cfg_pending        a configuration write is waiting to be applied
//   baud_div, parity_cfg, loopback_en   applied configuration
//   timeout_err        one-cycle pulse: the core never went busy
module uart_tx_sched #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned BUSY_TIMEOUT   = 64,
    parameter logic [15:0] RESET_BAUD_DIV = 16'd868
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [2:0]           grant_id,
    output logic [7:0]           host_tx_data,
    output logic                 host_tx_en,
    input  logic                 host_tx_busy,
    input  logic                 cfg_wr,
    input  logic [15:0]          cfg_baud_div,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_loopback,
    output logic                 cfg_pending,
    output logic [15:0]          baud_div,
    output logic [1:0]           parity_cfg,
    output logic                 loopback_en,
    output logic                 timeout_err
);

    localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         ptr;
    logic [CNT_W-1:0]   busy_cnt;

    logic [15:0]        shadow_baud;
    logic [1:0]         shadow_parity;
    logic               shadow_loopback;

    logic               any_valid;
    logic [2:0]         sel;
    logic [7:0]         sel_data;
    logic [NUM_REQ-1:0] sel_onehot;
    logic               grant_ok;
    logic               cfg_apply;
    logic               timed_out;

    // Round-robin search starting at ptr+1. Offsets are scanned from the
    // farthest to the nearest so the nearest valid requester is written last.
    always_comb begin
        any_valid  = 1'b0;
        sel        = '0;
        sel_data   = '0;
        sel_onehot = '0;
        for (int unsigned i = NUM_REQ; i > 0; i--) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (req_valid[j] && (j == (32'(ptr) + i) % NUM_REQ)) begin
                    any_valid  = 1'b1;
                    sel        = 3'(j);
                    sel_data   = req_data[8*j +: 8];
                    sel_onehot = NUM_REQ'(1) << j;
                end
            end
        end
    end

    // A pending configuration takes the idle cycle; no grant is issued then.
    assign cfg_apply = (state == IDLE) && cfg_pending;
    assign grant_ok  = (state == IDLE) && !cfg_pending && any_valid;
    assign req_ready = grant_ok ? sel_onehot : '0;
    assign timed_out = (state == WAIT_BUSY) && !host_tx_busy &&
                       (busy_cnt == CNT_W'(BUSY_TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (grant_ok) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (host_tx_busy)   state_nxt = WAIT_DONE;
                else if (timed_out) state_nxt = IDLE;
            end
            WAIT_DONE: if (!host_tx_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Host-side datapath. host_tx_en is high exactly in ISSUE, i.e. the
    // cycle after a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_tx_en   <= 1'b0;
            host_tx_data <= '0;
            grant_id     <= '0;
            ptr          <= 3'(NUM_REQ - 1);
            busy_cnt     <= '0;
            timeout_err  <= 1'b0;
        end else begin
            host_tx_en  <= grant_ok;
            timeout_err <= timed_out;
            if (grant_ok) begin
                host_tx_data <= sel_data;
                grant_id     <= sel;
                ptr          <= sel;
            end
            if (state == ISSUE)
                busy_cnt <= '0;
            else if (state == WAIT_BUSY && !host_tx_busy && !timed_out)
                busy_cnt <= busy_cnt + 1'b1;
        end
    end

    // Shadow capture and idle-time apply. A write landing on an apply edge
    // refills the shadow and keeps cfg_pending set for the next idle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_baud     <= RESET_BAUD_DIV;
            shadow_parity   <= '0;
            shadow_loopback <= 1'b0;
            cfg_pending     <= 1'b0;
            baud_div        <= RESET_BAUD_DIV;
            parity_cfg      <= '0;
            loopback_en     <= 1'b0;
        end else begin
            if (cfg_apply) begin
                baud_div    <= shadow_baud;
                parity_cfg  <= shadow_parity;
                loopback_en <= shadow_loopback;
            end
            if (cfg_wr) begin
                shadow_baud     <= cfg_baud_div;
                shadow_parity   <= cfg_parity;
                shadow_loopback <= cfg_loopback;
                cfg_pending     <= 1'b1;
            end else if (cfg_apply) begin
                cfg_pending <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmitter host port (host_tx_data / host_tx_en / host_tx_busy) between NUM_REQ byte requesters.
- Owns the UART configuration registers (baud_div, parity_cfg, loopback_en). New configuration is applied only between frames, so a frame is never sent with mixed settings.
- Sits between on-chip byte producers and the UART core, in the same clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BUSY_TIMEOUT, 64, maximum cycles to wait for host_tx_busy to rise after a host_tx_en pulse.
- RESET_BAUD_DIV, 16'd868, baud_div value loaded at reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
- req_ready  output  NUM_REQ  one-hot acceptance pulse, combinational.
- grant_id  output  3  index of the last accepted requester.
- host_tx_data  output  8  byte presented to the UART core.
- host_tx_en  output  1  one-cycle start pulse to the UART core.
- host_tx_busy  input  1  UART core busy indication.
- cfg_wr  input  1  configuration write strobe.
- cfg_baud_div  input  16  new baud divisor.
- cfg_parity  input  2  new parity setting.
- cfg_loopback  input  1  new loopback enable.
- cfg_pending  output  1  a configuration write is waiting to be applied.
- baud_div  output  16  applied baud divisor.
- parity_cfg  output  2  applied parity setting.
- loopback_en  output  1  applied loopback enable.
- timeout_err  output  1  one-cycle pulse: the UART core never went busy.

Behaviour:
- Reset values:
  - State IDLE; host_tx_en=0, host_tx_data=0, grant_id=0, timeout_err=0, cfg_pending=0.
  - baud_div=RESET_BAUD_DIV, parity_cfg=0, loopback_en=0.
  - Round-robin pointer set to NUM_REQ-1, so requester 0 has first priority.
  - All registered outputs are driven from flops.
- Reset asserted mid-frame aborts immediately to the reset values. The UART core is not notified.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If cfg_pending=1: copy the shadow registers to baud_div/parity_cfg/loopback_en on this edge and clear cfg_pending. No grant is issued in this cycle; configuration has priority over requesters.
  - Otherwise, if any req_valid is high: select the first valid requester searching from pointer+1 modulo NUM_REQ and pulse req_ready[sel] combinationally in this cycle. On the edge: host_tx_data<=req_data[sel], host_tx_en<=1, grant_id<=sel, pointer<=sel, go to ISSUE.
- ISSUE (exactly 1 cycle, host_tx_en=1): on the edge, host_tx_en<=0, clear the timeout counter, go to WAIT_BUSY.
- WAIT_BUSY:
  - If host_tx_busy=1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1, pulse timeout_err for 1 cycle and go to IDLE. The byte is dropped and the pointer remains at the granted requester.
- WAIT_DONE: when host_tx_busy=0, go to IDLE.
- Latency and throughput:
  - req_ready to host_tx_en rise: 1 cycle.
  - Minimum spacing between grants is 4 cycles plus the busy duration.
- req_ready is never asserted outside IDLE, and never asserted in a cycle in which a configuration is applied.
- The requester must hold req_valid and req_data stable until it sees req_ready. Deasserting req_valid before acceptance is permitted; the request is then simply not served.
- cfg_wr:
  - Captures cfg_* into the shadow registers and sets cfg_pending=1.
  - A repeated write while pending overwrites the shadow (last write wins).
  - cfg_wr in the same cycle as an apply: the outputs take the previous shadow values, the shadow takes the new values, and cfg_pending stays 1. The new values are applied on the next IDLE cycle.
- Configuration outputs never change outside IDLE.
- host_tx_busy high while in IDLE is ignored.

Test Plan:
- After reset, req_valid=4'b0001 with byte 0x55 → req_ready[0] pulses for 1 cycle; next cycle host_tx_en=1 and host_tx_data=0x55. Bench raises busy for 10 cycles → FSM returns to IDLE 1 cycle after busy falls; grant_id=0.
- req_valid=4'b1111 held, 4 frames → grant order 0,1,2,3, then 0 again. Repeat with req_valid=4'b1010 → order 1,3,1,3.
- cfg_wr with baud_div=16'd434 while in WAIT_DONE → cfg_pending=1 and baud_div stays 868 until busy falls. The apply cycle shows baud_div=434 and no req_ready; the grant follows on the next cycle.
- Bench never raises busy after host_tx_en → timeout_err pulses exactly BUSY_TIMEOUT cycles after WAIT_BUSY entry; state returns to IDLE; the next grant goes to the following requester.
- cfg_wr (parity=2'b01) in the same cycle as the apply of a pending parity=2'b10 → parity_cfg=2'b10 first, then 2'b01 on the next IDLE cycle; cfg_pending clears only after the second apply.
- rst_n pulsed low during WAIT_DONE → all outputs return to reset values asynchronously, including baud_div=868. After release, requester 0 has priority again.
